// File: rtl/seg7_reader.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_reader
//  Purpose  : Snoops a multiplexed 4-digit 7-segment bus, filters each
//             segment/enable pair for stability, decodes the pattern back to
//             BCD and presents complete 4-digit frames on valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seven_seg,
    input  logic [3:0]  dig_en,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] bcd,
    output logic [3:0]  err
);

    localparam logic [7:0] c_stable    = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_stable_m1 = 8'(STABLE_CYCLES - 1);

    // Frame machine: accumulating digits with no frame held, or holding one
    localparam logic [0:0] c_st_accum = 1'b0;
    localparam logic [0:0] c_st_held  = 1'b1;

    logic [6:0]  r_p_seg;
    logic [3:0]  r_p_en;
    logic [7:0]  r_cnt;
    logic        r_strobe;
    logic [15:0] r_cap_dig;
    logic [3:0]  r_cap_err;
    logic [3:0]  r_mask;
    logic [0:0]  r_state;
    logic [15:0] r_bcd;
    logic [3:0]  r_err;

    logic        w_changed;
    logic        w_en_onehot;
    logic [3:0]  w_dec_dig;
    logic        w_dec_err;
    logic        w_full;
    logic        w_load;
    logic        w_hs;
    logic [3:0]  w_mask_set;

    // The new sample differs from the pair currently held in the input stage
    assign w_changed   = (seven_seg != r_p_seg) || (dig_en != r_p_en);
    // While the pair is unchanged, r_p_en equals dig_en, so checking it suffices
    assign w_en_onehot = (r_p_en != 4'd0) && ((r_p_en & (r_p_en - 4'd1)) == 4'd0);

    assign out_valid  = (r_state == c_st_held);
    assign bcd        = r_bcd;
    assign err        = r_err;
    assign w_full     = (r_mask == 4'hF);
    assign w_load     = w_full && (!out_valid || out_ready);
    assign w_hs       = out_valid && out_ready;
    assign w_mask_set = r_strobe ? r_p_en : 4'd0;

    // Input stage, saturating stability counter and one-cycle capture strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_seg  <= 7'd0;
            r_p_en   <= 4'd0;
            r_cnt    <= 8'd0;
            r_strobe <= 1'b0;
        end else begin
            r_p_seg <= seven_seg;
            r_p_en  <= dig_en;
            if (w_changed) begin
                r_cnt <= 8'd1;
            end else if (r_cnt < c_stable) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // Fires on the edge where the count steps to STABLE_CYCLES; a
            // non-one-hot enable suppresses it for the whole stable window.
            r_strobe <= !w_changed && (r_cnt == c_stable_m1) && w_en_onehot;
        end
    end

    // Reverse segment decode of the stable pattern
    always_comb begin
        w_dec_dig = 4'hF;
        w_dec_err = 1'b0;
        case (r_p_seg)
            7'b1111110: w_dec_dig = 4'd0;
            7'b0110000: w_dec_dig = 4'd1;
            7'b1101101: w_dec_dig = 4'd2;
            7'b1111001: w_dec_dig = 4'd3;
            7'b0110011: w_dec_dig = 4'd4;
            7'b1011011: w_dec_dig = 4'd5;
            7'b1011111: w_dec_dig = 4'd6;
            7'b1110000: w_dec_dig = 4'd7;
            7'b1111111: w_dec_dig = 4'd8;
            7'b1110011: w_dec_dig = 4'd9;
            default: begin
                w_dec_dig = 4'hF;
                w_dec_err = 1'b1;
            end
        endcase
    end

    // Capture registers: last captured value per digit wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_dig <= 16'd0;
            r_cap_err <= 4'd0;
        end else if (r_strobe) begin
            for (int i = 0; i < 4; i++) begin
                if (r_p_en[i]) begin
                    r_cap_dig[4*i +: 4] <= w_dec_dig;
                    r_cap_err[i]        <= w_dec_err;
                end
            end
        end
    end

    // Frame machine: load uses pre-capture values, a same-cycle capture lands
    // in the freshly cleared mask and counts toward the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_accum;
            r_mask  <= 4'd0;
            r_bcd   <= 16'd0;
            r_err   <= 4'd0;
        end else begin
            r_mask <= (w_load ? 4'd0 : r_mask) | w_mask_set;
            case (r_state)
                c_st_accum: begin
                    if (w_load) begin
                        r_state <= c_st_held;
                        r_bcd   <= r_cap_dig;
                        r_err   <= r_cap_err;
                    end
                end
                default: begin
                    if (w_load) begin
                        r_state <= c_st_held;
                        r_bcd   <= r_cap_dig;
                        r_err   <= r_cap_err;
                    end else if (w_hs) begin
                        r_state <= c_st_accum;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_reader
//  Purpose  : Self-checking bench for seg7_reader: directed scenarios plus
//             randomized bus traffic against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_reader;

    localparam int STABLE_CYCLES = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [6:0]  seven_seg = 7'd0;
    logic [3:0]  dig_en    = 4'd0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] bcd;
    logic [3:0]  err;

    always #5 clk = ~clk;

    seg7_reader #(.STABLE_CYCLES(STABLE_CYCLES)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seven_seg (seven_seg),
        .dig_en    (dig_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bcd       (bcd),
        .err       (err)
    );

    // Legal segment patterns, index = digit value
    logic [6:0] c_pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1110011};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {err, digit}
    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++) begin
            if (c_pat[d] == s) return {1'b0, 4'(d)};
        end
        return {1'b1, 4'hF};
    endfunction

    // ---------------- reference model ----------------
    int         m_run;
    logic [6:0] m_prev_seg;
    logic [3:0] m_prev_en;
    bit         m_pend;
    logic [6:0] m_pend_seg;
    logic [3:0] m_pend_en;
    logic [3:0] m_dig [4];
    logic [3:0] m_cerr;
    logic [3:0] m_mask;
    bit         m_valid;
    logic [15:0] m_bcd;
    logic [3:0]  m_err;

    task automatic model_reset();
        m_run = 0; m_prev_seg = 7'd0; m_prev_en = 4'd0;
        m_pend = 0; m_pend_seg = 7'd0; m_pend_en = 4'd0;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
        m_cerr = 4'd0; m_mask = 4'd0; m_valid = 0; m_bcd = 16'd0; m_err = 4'd0;
    endtask

    // One rising edge: frame output first (pre-capture values), then the
    // capture that became due, then the new bus sample
    task automatic model_edge();
        bit load;
        logic [4:0] dec;
        load = (m_mask == 4'hF) && (!m_valid || out_ready);
        if (load) begin
            for (int i = 0; i < 4; i++) m_bcd[4*i +: 4] = m_dig[i];
            m_err   = m_cerr;
            m_valid = 1;
            m_mask  = 4'd0;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (m_pend) begin
            dec = ref_decode(m_pend_seg);
            for (int i = 0; i < 4; i++) begin
                if (m_pend_en[i]) begin
                    m_dig[i]  = dec[3:0];
                    m_cerr[i] = dec[4];
                    m_mask[i] = 1'b1;
                end
            end
            m_pend = 0;
        end
        // A pair seen STABLE_CYCLES times in a row is written one edge later
        if (seven_seg == m_prev_seg && dig_en == m_prev_en) m_run++;
        else m_run = 1;
        m_prev_seg = seven_seg;
        m_prev_en  = dig_en;
        if (m_run == STABLE_CYCLES && $countones(dig_en) == 1) begin
            m_pend     = 1;
            m_pend_seg = seven_seg;
            m_pend_en  = dig_en;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    int          n_valid_cycles;
    logic [15:0] last_bcd;
    logic [3:0]  last_err;

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("bcd", bcd, m_bcd);
        chk("err", err, m_err);
        if (out_valid) begin
            n_valid_cycles++;
            last_bcd = bcd;
            last_err = err;
        end
    endtask

    task automatic hold(input logic [3:0] en, input logic [6:0] seg, input int n);
        dig_en    = en;
        seven_seg = seg;
        repeat (n) tick();
    endtask

    task automatic frame4(input int d0, input int d1, input int d2, input int d3);
        hold(4'b0001, c_pat[d0], 8);
        hold(4'b0010, c_pat[d1], 8);
        hold(4'b0100, c_pat[d2], 8);
        hold(4'b1000, c_pat[d3], 8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] en;
        logic [6:0] seg;
        int         n;

        model_reset();
        #23;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_bcd", bcd, 16'h0000);
        chk("reset_err", err, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame 3,1,4,1
        out_ready = 1'b1;
        n_valid_cycles = 0;
        frame4(3, 1, 4, 1);
        hold(4'b0000, 7'd0, 6);
        chk("basic_nvalid", n_valid_cycles, 1);
        chk("basic_bcd", last_bcd, 16'h1413);
        chk("basic_err", last_err, 4'h0);

        // Illegal pattern on digit 2
        n_valid_cycles = 0;
        hold(4'b0001, c_pat[0], 8);
        hold(4'b0010, c_pat[9], 8);
        hold(4'b0100, 7'b0000001, 8);
        hold(4'b1000, c_pat[7], 8);
        hold(4'b0000, 7'd0, 6);
        chk("inval_nvalid", n_valid_cycles, 1);
        chk("inval_bcd", last_bcd, 16'h7F90);
        chk("inval_err", last_err, 4'b0100);

        // Short glitch and multi-hot enable must not capture digit 0
        n_valid_cycles = 0;
        hold(4'b0001, c_pat[5], 3);
        hold(4'b0011, c_pat[5], 10);
        hold(4'b0010, c_pat[2], 8);
        hold(4'b0100, c_pat[3], 8);
        hold(4'b1000, c_pat[4], 8);
        hold(4'b0000, 7'd0, 6);
        chk("glitch_noframe", n_valid_cycles, 0);
        hold(4'b0001, c_pat[6], 8);
        hold(4'b0000, 7'd0, 4);
        chk("glitch_nvalid", n_valid_cycles, 1);
        chk("glitch_bcd", last_bcd, 16'h4326);

        // Backpressure: frame A held while frame B completes
        out_ready = 1'b0;
        frame4(4, 3, 2, 1);
        frame4(8, 7, 6, 5);
        hold(4'b0000, 7'd0, 4);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_hold_bcd", bcd, 16'h1234);
        out_ready = 1'b1;
        tick();
        chk("bp_next_valid", out_valid, 1'b1);
        chk("bp_next_bcd", bcd, 16'h5678);
        tick();
        chk("bp_drain_valid", out_valid, 1'b0);

        // Overwrite of digit 0 before the frame completes
        n_valid_cycles = 0;
        hold(4'b0001, c_pat[2], 8);
        hold(4'b0001, c_pat[5], 8);
        hold(4'b0010, c_pat[1], 8);
        hold(4'b0100, c_pat[1], 8);
        hold(4'b1000, c_pat[1], 8);
        hold(4'b0000, 7'd0, 4);
        chk("ovw_nvalid", n_valid_cycles, 1);
        chk("ovw_bcd", last_bcd, 16'h1115);

        // Asynchronous reset after two digits captured
        hold(4'b0001, c_pat[9], 8);
        hold(4'b0010, c_pat[8], 8);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_bcd", bcd, 16'h0000);
        chk("arst_err", err, 4'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_valid_cycles = 0;
        hold(4'b0100, c_pat[7], 8);
        hold(4'b1000, c_pat[3], 8);
        hold(4'b0000, 7'd0, 6);
        chk("rst_noframe", n_valid_cycles, 0);
        hold(4'b0001, c_pat[9], 8);
        hold(4'b0010, c_pat[8], 8);
        hold(4'b0000, 7'd0, 4);
        chk("rst_nvalid", n_valid_cycles, 1);
        chk("rst_bcd", last_bcd, 16'h3789);

        // Randomized bus traffic with random backpressure
        for (int k = 0; k < 250; k++) begin
            en  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            seg = ($urandom_range(0, 9) == 0) ? 7'($urandom) : c_pat[$urandom_range(0, 9)];
            n   = $urandom_range(1, 10);
            dig_en    = en;
            seven_seg = seg;
            repeat (n) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
